// File: rtl/api_timer_mc.sv
// Multi-channel API timeout timer: CH independent W-bit counters on a shared prescaler.
// Optional sticky interrupt is enabled by defining API_TIMER_IRQ_EN.
module api_timer_mc #(
  parameter int CH    = 4,
  parameter int W     = 28,
  parameter int PRE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_rst,
  input  logic [PRE_W-1:0]  reg_prescale,
  input  logic [CH*W-1:0]   reg_timeout,
  input  logic [CH-1:0]     reg_periodic,
  input  logic [CH-1:0]     start,
  input  logic [CH-1:0]     stop,
  input  logic [CH-1:0]     irq_clr,
  output logic [CH-1:0]     timeout_busy,
  output logic [CH-1:0]     timeout_done,
  output logic              irq
);

  logic [PRE_W-1:0] r_pc;
  logic             w_tick;
  logic [CH-1:0]    w_expire;
  logic [CH-1:0]    r_done;

  // Free-running prescaler; start does not realign it, only reg_rst does.
  assign w_tick = (r_pc == reg_prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (reg_rst || w_tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] r_cnt;
      logic [W-1:0] w_to;
      logic [W-1:0] w_t;
      logic         w_run;

      assign w_to  = reg_timeout[gi*W +: W];
      assign w_t   = (w_to == '0) ? W'(1) : w_to;
      assign w_run = (r_cnt != '0);
      // Expiry only counts when no higher-priority event claims this edge.
      assign w_expire[gi] = w_tick && w_run && (r_cnt >= w_t) &&
                            !reg_rst && !stop[gi] && !start[gi];
      assign timeout_busy[gi] = w_run;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (reg_rst || stop[gi]) begin
          r_cnt <= '0;
        end else if (start[gi]) begin
          r_cnt <= W'(1);
        end else if (w_expire[gi]) begin
          r_cnt <= reg_periodic[gi] ? W'(1) : '0;
        end else if (w_tick && w_run) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= '0;
    end else begin
      r_done <= w_expire;
    end
  end

  assign timeout_done = r_done;

`ifdef API_TIMER_IRQ_EN
  logic [CH-1:0] r_pend;
  logic          r_irq;

  // Set dominates clear so an expiry landing on an irq_clr is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else if (reg_rst) begin
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~irq_clr) | w_expire;
      r_irq  <= |r_pend;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_clr;
  assign w_unused_irq_clr = ^irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_api_timer_mc.sv
// Directed bench for api_timer_mc: one-shot, periodic, prescaler phases, collisions, irq.
module tb_api_timer_mc;
  localparam int CH    = 4;
  localparam int W     = 28;
  localparam int PRE_W = 8;

  logic              clk;
  logic              rst;
  logic              reg_rst;
  logic [PRE_W-1:0]  reg_prescale;
  logic [CH*W-1:0]   reg_timeout;
  logic [CH-1:0]     reg_periodic;
  logic [CH-1:0]     start;
  logic [CH-1:0]     stop;
  logic [CH-1:0]     irq_clr;
  logic [CH-1:0]     timeout_busy;
  logic [CH-1:0]     timeout_done;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;

  api_timer_mc #(.CH(CH), .W(W), .PRE_W(PRE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_rst      (reg_rst),
    .reg_prescale (reg_prescale),
    .reg_timeout  (reg_timeout),
    .reg_periodic (reg_periodic),
    .start        (start),
    .stop         (stop),
    .irq_clr      (irq_clr),
    .timeout_busy (timeout_busy),
    .timeout_done (timeout_done),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_to(input int c, input int t);
    reg_timeout[c*W +: W] = W'(t);
  endtask

  task automatic pulse_start(input int c);
    start[c] = 1'b1;
    step();
    start = '0;
  endtask

  // Counts busy cycles of channel c (bounded), then checks the trailing done pulse.
  task automatic measure(input int c, input int exp_len, input string tag);
    int n = 0;
    int d = 0;
    while (timeout_busy[c] === 1'b1 && n < 200) begin
      if (timeout_done[c] !== 1'b0) d++;
      n++;
      step();
    end
    chk({tag, "_len"}, n, exp_len);
    chk({tag, "_done_while_busy"}, d, 0);
    chk({tag, "_done"}, timeout_done[c], 1);
    step();
    chk({tag, "_done_gone"}, timeout_done[c], 0);
    chk({tag, "_idle"}, timeout_busy[c], 0);
  endtask

  initial begin
    int exp_pre[4];
    int dcnt;
    exp_pre = '{15, 14, 13, 16};

    rst = 1'b1; reg_rst = 1'b0; reg_prescale = '0; reg_timeout = '0;
    reg_periodic = '0; start = '0; stop = '0; irq_clr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", timeout_busy, 0);
    chk("reset_done", timeout_done, 0);
    chk("reset_irq", irq, 0);
    rst = 1'b0;
    step();

    // One-shot, T=5, prescale 0
    set_to(0, 5);
    pulse_start(0);
    measure(0, 5, "oneshot5");

    // T=0 and T=1 both behave as one tick
    set_to(0, 0);
    pulse_start(0);
    measure(0, 1, "timeout0");
    set_to(0, 1);
    pulse_start(0);
    measure(0, 1, "timeout1");

    // Periodic ch1, T=3
    set_to(1, 3);
    reg_periodic[1] = 1'b1;
    pulse_start(1);
    chk("per_busy0", timeout_busy[1], 1);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("per_done_%0d", i), timeout_done[1], (i % 3 == 0) ? 1 : 0);
      chk($sformatf("per_busy_%0d", i), timeout_busy[1], 1);
    end
    stop[1] = 1'b1;
    step();
    stop = '0;
    chk("per_stop_busy", timeout_busy[1], 0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (timeout_done[1] !== 1'b0) dcnt++;
    end
    chk("per_stop_nodone", dcnt, 0);
    reg_periodic = '0;

    // Prescaler 3, T=4: start at each pc phase after a reg_rst alignment
    reg_prescale = 8'd3;
    set_to(0, 4);
    for (int d = 1; d <= 4; d++) begin
      reg_rst = 1'b1;
      step();
      reg_rst = 1'b0;
      repeat (d - 1) step();
      pulse_start(0);
      measure(0, exp_pre[d-1], $sformatf("pre_phase%0d", d));
    end
    reg_prescale = '0;
    reg_rst = 1'b1;
    step();
    reg_rst = 1'b0;

    // start on the expiry edge of ch2 restarts without a done pulse
    set_to(2, 3);
    pulse_start(2);
    step();
    step();
    start[2] = 1'b1;
    step();
    start = '0;
    chk("coll_start_nodone", timeout_done[2], 0);
    chk("coll_start_busy", timeout_busy[2], 1);
    measure(2, 3, "coll_restart");

    // start and stop together: stop wins
    set_to(3, 10);
    pulse_start(3);
    step();
    start[3] = 1'b1;
    stop[3] = 1'b1;
    step();
    start = '0;
    stop = '0;
    chk("startstop_busy", timeout_busy[3], 0);
    chk("startstop_done", timeout_done[3], 0);

    // reg_rst mid-run on all channels
    for (int c = 0; c < CH; c++) set_to(c, 20);
    start = '1;
    step();
    start = '0;
    chk("all_busy", timeout_busy, 4'hf);
    repeat (3) step();
    reg_rst = 1'b1;
    step();
    reg_rst = 1'b0;
    chk("regrst_busy", timeout_busy, 0);
    chk("regrst_done", timeout_done, 0);
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (timeout_done !== '0) dcnt++;
    end
    chk("regrst_nodone", dcnt, 0);

    // Interrupt behaviour
    set_to(0, 2);
    pulse_start(0);
    measure(0, 2, "irq_run");
`ifdef API_TIMER_IRQ_EN
    chk("irq_set", irq, 1);
    step();
    chk("irq_sticky", irq, 1);
    set_to(0, 1);
    pulse_start(0);
    irq_clr[0] = 1'b1;
    step();
    irq_clr = '0;
    step();
    chk("irq_set_beats_clr", irq, 1);
    irq_clr[0] = 1'b1;
    step();
    irq_clr = '0;
    step();
    chk("irq_cleared", irq, 0);
`else
    chk("irq_off_after_expiry", irq, 0);
    irq_clr[0] = 1'b1;
    step();
    irq_clr = '0;
    step();
    chk("irq_off_after_clr", irq, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
